// File: rtl/adder_tree_acc_q_if.sv
// Beat/result bundle for adder_tree_acc_q.
// master drives beats and samples results; slave is the adder tree.
interface adder_tree_acc_q_if #(
  parameter int NUM_IN  = 4,
  parameter int IN_W    = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
);
  logic                     in_valid;
  logic                     in_first;
  logic                     in_last;
  logic [NUM_IN*IN_W-1:0]   in_data;
  logic [SHIFT_W-1:0]       shift;
  logic                     round_en;
  logic                     out_valid;
  logic [OUT_W-1:0]         out_data;
  logic                     out_sat;

  modport master (
    output in_valid, in_first, in_last,
    output in_data, shift, round_en,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_first, in_last,
    input  in_data, shift, round_en,
    output out_valid, out_data, out_sat
  );
endinterface

// File: rtl/adder_tree_acc_q.sv
// Pipelined signed adder tree, per-packet accumulator, shift/round/saturate.
// Ports: clk, rst_n (async low), clr (sync flush), bus (slave: beats in, results out).
module adder_tree_acc_q #(
  parameter int NUM_IN  = 4,
  parameter int IN_W    = 32,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  adder_tree_acc_q_if.slave bus
);

  localparam int L  = $clog2(NUM_IN);
  localparam int NP = 1 << L;
  localparam int H  = NP / 2;

  typedef struct packed {
    logic               v;
    logic               f;
    logic               l;
    logic [SHIFT_W-1:0] sh;
    logic               rd;
  } sb_t;

  // Nodes are carried at ACC_W; sign extension keeps every sum exact.
  logic signed [ACC_W-1:0] tr     [0:L][0:NP-1];
  logic signed [ACC_W-1:0] node_q [1:L][0:H-1];
  sb_t                     sb     [0:L];
  sb_t                     sb_q   [1:L];

  always_comb begin
    for (int l = 0; l <= L; l++) begin
      for (int k = 0; k < NP; k++) begin
        tr[l][k] = '0;
      end
    end
    for (int k = 0; k < NUM_IN; k++) begin
      tr[0][k] = ACC_W'($signed(bus.in_data[k*IN_W +: IN_W]));
    end
    for (int l = 1; l <= L; l++) begin
      for (int k = 0; k < H; k++) begin
        tr[l][k] = node_q[l][k];
      end
    end
    sb[0] = '{v: bus.in_valid, f: bus.in_first,
              l: bus.in_last, sh: bus.shift,
              rd: bus.round_en};
    for (int l = 1; l <= L; l++) begin
      sb[l] = sb_q[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 1; l <= L; l++) begin
        sb_q[l] <= '0;
        for (int k = 0; k < H; k++) begin
          node_q[l][k] <= '0;
        end
      end
    end else begin
      for (int l = 1; l <= L; l++) begin
        for (int k = 0; k < H; k++) begin
          node_q[l][k] <= tr[l-1][2*k] + tr[l-1][2*k+1];
        end
        sb_q[l] <= sb[l-1];
        if (clr) begin
          sb_q[l].v <= 1'b0;
        end
      end
    end
  end

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_q;
  logic                    a_last_q;
  logic [SHIFT_W-1:0]      a_sh_q;
  logic                    a_rd_q;

  assign sum = tr[L][0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      a_last_q <= 1'b0;
      a_sh_q   <= '0;
      a_rd_q   <= 1'b0;
    end else if (clr) begin
      acc_q    <= '0;
      a_last_q <= 1'b0;
    end else begin
      a_last_q <= sb[L].v & sb[L].l;
      if (sb[L].v) begin
        acc_q  <= sb[L].f ? sum : acc_q + sum;
        a_sh_q <= sb[L].sh;
        a_rd_q <= sb[L].rd;
      end
    end
  end

  // One extra bit so the rounding bias cannot wrap the accumulator.
  localparam logic signed [ACC_W:0] QMAX =
    $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] QMIN = ~QMAX;

  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] r;
  logic signed [ACC_W:0] q;
  logic [OUT_W-1:0]      q_dat;
  logic                  q_sat;

  always_comb begin
    rnd = '0;
    if (a_rd_q && a_sh_q != '0) begin
      rnd = $signed({{ACC_W{1'b0}}, 1'b1} << (a_sh_q - 1'b1));
    end
    r = $signed({acc_q[ACC_W-1], acc_q}) + rnd;
    q = r >>> a_sh_q;
    q_sat = 1'b0;
    q_dat = q[OUT_W-1:0];
    if (q > QMAX) begin
      q_sat = 1'b1;
      q_dat = QMAX[OUT_W-1:0];
    end else if (q < QMIN) begin
      q_sat = 1'b1;
      q_dat = QMIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      bus.out_valid <= a_last_q & ~clr;
      if (a_last_q && !clr) begin
        bus.out_data <= q_dat;
        bus.out_sat  <= q_sat;
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_acc_q.sv
// Scoreboard bench for adder_tree_acc_q: directed cases plus random packets.
// Expected results come from an arithmetic model and are checked by a monitor.
module tb_adder_tree_acc_q;

  localparam int NUM_IN  = 4;
  localparam int IN_W    = 32;
  localparam int ACC_W   = 40;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int LAT     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  adder_tree_acc_q_if #(
    .NUM_IN(NUM_IN), .IN_W(IN_W),
    .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
  ) vif ();

  adder_tree_acc_q #(
    .NUM_IN(NUM_IN), .IN_W(IN_W), .ACC_W(ACC_W),
    .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(vif)
  );

  typedef struct {
    int d;
    bit s;
    int cyc;
  } exp_t;

  exp_t   sbq[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     cyc = 0;
  longint macc = 0;
  int     hold_d = 0;
  bit     hold_s = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic longint wrap_acc(longint x);
    return (x <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  task automatic quant(input longint a, input int sh, input bit rd,
                       output int d, output bit s);
    longint r;
    longint q;
    r = (rd && sh != 0) ? a + (longint'(1) <<< (sh - 1)) : a;
    q = r >>> sh;
    s = 1'b1;
    if (q > 127) d = 127;
    else if (q < -128) d = -128;
    else begin
      d = int'(q);
      s = 1'b0;
    end
  endtask

  task automatic beat(input int a0, input int a1, input int a2, input int a3,
                      input bit f, input bit l, input int sh, input bit rd,
                      input bit c);
    longint s;
    exp_t   e;
    @(negedge clk);
    vif.in_valid = 1'b1;
    vif.in_first = f;
    vif.in_last  = l;
    vif.in_data  = {a3, a2, a1, a0};
    vif.shift    = sh[SHIFT_W-1:0];
    vif.round_en = rd;
    clr          = c;
    if (c) begin
      macc = 0;
    end else begin
      s = longint'(a0) + longint'(a1) + longint'(a2) + longint'(a3);
      macc = f ? wrap_acc(s) : wrap_acc(macc + s);
      if (l) begin
        quant(macc, sh, rd, e.d, e.s);
        e.cyc = cyc + LAT;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vif.in_valid = 1'b0;
      vif.in_first = 1'($urandom);
      vif.in_last  = 1'($urandom);
      vif.in_data  = {$urandom, $urandom, $urandom, $urandom};
      clr          = 1'b0;
    end
  endtask

  task automatic clr_only();
    @(negedge clk);
    vif.in_valid = 1'b0;
    clr          = 1'b1;
    macc         = 0;
  endtask

  // Monitor: pops one expectation per pulse, checks hold between pulses.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (vif.out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("out_data", longint'($signed(vif.out_data)), e.d);
          chk("out_sat", vif.out_sat, e.s);
          chk("latency_cycle", cyc, e.cyc);
          hold_d = e.d;
          hold_s = e.s;
        end
      end else begin
        chk("hold_data", longint'($signed(vif.out_data)), hold_d);
        chk("hold_sat", vif.out_sat, hold_s);
      end
    end
  end

  task automatic check_reset_zero(input string tag);
    chk({tag, "_valid"}, vif.out_valid, 0);
    chk({tag, "_data"}, vif.out_data, 0);
    chk({tag, "_sat"}, vif.out_sat, 0);
  endtask

  initial begin
    int len;
    int sh;
    bit big;
    int v[4];
    vif.in_valid = 1'b0;
    vif.in_first = 1'b0;
    vif.in_last  = 1'b0;
    vif.in_data  = '0;
    vif.shift    = '0;
    vif.round_en = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_zero("reset_init");
    rst_n = 1'b1;

    beat(100, 200, 300, 400, 1, 1, 3, 0, 0);
    idle(6);

    beat(-1, -2, 0, 0, 1, 1, 1, 1, 0);
    beat(-1, -2, 0, 0, 1, 1, 1, 0, 0);
    idle(6);

    beat(10, 0, 0, 0, 1, 0, 9, 1, 0);
    beat(5, 5, 5, 5, 0, 0, 7, 1, 0);
    beat(-5, 0, 0, 0, 0, 1, 0, 0, 0);
    beat(1, 1, 1, 1, 1, 1, 0, 0, 0);
    idle(6);

    beat(1000, 0, 0, 0, 1, 1, 0, 0, 0);
    beat(-1000, 0, 0, 0, 1, 1, 0, 0, 0);
    beat(-64, -64, 0, 0, 1, 1, 0, 0, 0);
    beat(64, 63, 0, 0, 1, 1, 0, 0, 0);
    idle(6);

    beat(7, 8, 9, 10, 1, 0, 0, 0, 0);
    beat(1, 2, 3, 4, 0, 0, 0, 0, 0);
    beat(5, 5, 5, 5, 0, 1, 0, 0, 1);
    idle(6);
    beat(1, 2, 3, 4, 1, 1, 0, 0, 0);
    idle(2);
    beat(30, 30, 0, 0, 1, 0, 0, 0, 0);
    clr_only();
    beat(-3, 0, 0, 0, 1, 1, 0, 0, 0);
    idle(6);

    beat(50, 0, 0, 0, 1, 1, 0, 0, 0);
    beat(60, 0, 0, 0, 1, 1, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_zero("reset_mid");
    sbq.delete();
    macc   = 0;
    hold_d = 0;
    hold_s = 0;
    vif.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(1, 5);
      big = ($urandom_range(0, 3) == 0);
      sh  = big ? $urandom_range(0, 31) : $urandom_range(0, 6);
      for (int b = 0; b < len; b++) begin
        for (int k = 0; k < 4; k++) begin
          v[k] = big ? int'($urandom) : $urandom_range(0, 600) - 300;
        end
        beat(v[0], v[1], v[2], v[3], b == 0, b == len - 1,
             sh, 1'($urandom), 0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    idle(1);

    for (int t = 0; t < 20 && sbq.size() != 0; t++) @(negedge clk);
    chk("drain_queue_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
